// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types for the data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  localparam int c_max_wait_cycles = 15;

  // funct3 values that have a store meaning (SB/SH/SW)
  function automatic logic is_store_mode(input logic [2:0] mode);
    return (mode == LB) || (mode == LH) || (mode == LW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// Module      : mem_align
// Description : Combinational lane steering, extension and access checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata,
  output logic        err
);

  logic        w_misaligned;
  logic        w_illegal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_misaligned = 1'b0;
    w_illegal    = 1'b0;
    case (mode[1:0])
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = offset[0];
      2'b10:   w_misaligned = |offset;
      default: w_illegal    = 1'b1;
    endcase
    if (we && !is_store_mode(mode)) begin
      w_illegal = 1'b1;
    end
    if (!we && mode[2] && mode[1]) begin
      w_illegal = 1'b1;
    end
    err = w_misaligned | w_illegal;
  end

  // Narrow stores replicate the source across lanes; byte enables pick the lane.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    case (mode[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    if (err || !we) begin
      byte_en = 4'b0000;
    end
  end

  always_comb begin
    w_byte = 8'(rword >> {offset, 3'b000});
    w_half = offset[1] ? rword[31:16] : rword[15:0];
    case (mode[1:0])
      2'b00:   rdata = mode[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   rdata = mode[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   rdata = rword;
      default: rdata = 32'd0;
    endcase
    if (err || we) begin
      rdata = 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Load/store responder with fixed latency and valid/ready ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         c_idx_w     = $clog2(DEPTH_WORDS);
  localparam logic       c_no_wait   = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_wait_last = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  resp_state_e          r_state;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic [c_idx_w-1:0]   r_idx;
  logic [1:0]           r_offset;
  logic [2:0]           r_mode;
  logic [31:0]          r_wdata;
  logic                 r_resp_valid;
  logic [31:0]          r_resp_rdata;
  logic                 r_resp_err;
  logic [31:0]          r_mem [DEPTH_WORDS];

  logic                 w_idle;
  logic                 w_enter_resp;
  logic                 w_cur_we;
  logic [c_idx_w-1:0]   w_cur_idx;
  logic [1:0]           w_cur_offset;
  logic [2:0]           w_cur_mode;
  logic [31:0]          w_cur_wdata;
  logic [3:0]           w_byte_en;
  logic [31:0]          w_wdata_lane;
  logic [31:0]          w_load_data;
  logic                 w_err;
  logic                 w_unused_addr;

  assign w_idle       = (r_state == IDLE);
  assign w_enter_resp = (w_idle && req_valid && c_no_wait) ||
                        ((r_state == WAIT) && (r_cnt == c_wait_last));

  // With zero latency the response is formed on the accepting edge, so the
  // datapath must see the live request instead of the not-yet-loaded registers.
  assign w_cur_we     = w_idle ? req_we               : r_we;
  assign w_cur_idx    = w_idle ? req_addr[2 +: c_idx_w] : r_idx;
  assign w_cur_offset = w_idle ? req_addr[1:0]        : r_offset;
  assign w_cur_mode   = w_idle ? req_mode             : r_mode;
  assign w_cur_wdata  = w_idle ? req_wdata            : r_wdata;

  assign w_unused_addr = ^req_addr[31:2+c_idx_w];

  mem_align u_align (
    .we         (w_cur_we),
    .mode       (w_cur_mode),
    .offset     (w_cur_offset),
    .wdata      (w_cur_wdata),
    .rword      (r_mem[w_cur_idx]),
    .byte_en    (w_byte_en),
    .wdata_lane (w_wdata_lane),
    .rdata      (w_load_data),
    .err        (w_err)
  );

  // Storage has no reset; the rst gate drops a store caught by reset.
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) begin
          r_mem[w_cur_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_offset     <= 2'd0;
      r_mode       <= 3'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_idx    <= req_addr[2 +: c_idx_w];
            r_offset <= req_addr[1:0];
            r_mode   <= req_mode;
            r_wdata  <= req_wdata;
            r_cnt    <= 4'd0;
            if (c_no_wait) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_load_data;
              r_resp_err   <= w_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == c_wait_last) begin
            r_state      <= RESP;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load_data;
            r_resp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for data_mem_responder with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int WAIT_CYCLES = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_mode;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          tag;
  } exp_t;

  exp_t  exp_q[$];
  string names[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_mode   (req_mode),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always begin
    @(negedge clk);
    #1;
    if (rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({names[e.tag], "_rdata"}, resp_rdata, e.d);
        chk({names[e.tag], "_err"}, 32'(resp_err), 32'(e.e));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e,
                       input int hold, input string name);
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (hold > 0) resp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    e.d   = exp_d;
    e.e   = exp_e;
    e.tag = names.size();
    names.push_back(name);
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble request fields after acceptance; they must be ignored.
    req_valid = 1'b0;
    req_we    = ~we;
    req_mode  = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    for (int i = 0; i < hold; i++) begin
      chk({name, "_bp_valid"}, 32'(resp_valid), 32'd1);
      chk({name, "_bp_rdata"}, resp_rdata, exp_d);
      chk({name, "_bp_req_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    chk({name, "_req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_mode   = 3'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0, "sw_10");
    issue(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0, "lw_10_a");
    issue(1'b1, 3'b000, 32'h11, 32'hAAAAAA55, 32'h0,        1'b0, 0, "sb_11");
    issue(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 0, "lw_10_b");
    issue(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 0, "lb_13");
    issue(1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0, 0, "lbu_13");
    issue(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 0, "lh_12");
    issue(1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 0, "lhu_12");
    issue(1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 0, "lw_12_mis");
    issue(1'b1, 3'b001, 32'h11, 32'h00001234, 32'h0,        1'b1, 0, "sh_11_mis");
    issue(1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 0, "ld_mode3");
    issue(1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1, 0, "ld_mode6");
    issue(1'b1, 3'b100, 32'h10, 32'h00000000, 32'h0,        1'b1, 0, "st_mode4");
    issue(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 0, "lw_10_c");
    issue(1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0,        1'b0, 0, "sh_12");
    issue(1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 5, "lw_10_bp");
    issue(1'b1, 3'b010, 32'h1000, 32'h1,      32'h0,        1'b0, 0, "sw_1000");
    issue(1'b0, 3'b010, 32'h0,  32'h0,        32'h1,        1'b0, 0, "lw_0_wrap");

    // Reset while a store waits: it must be dropped.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_mode  = 3'b010;
    req_addr  = 32'h0;
    req_wdata = 32'h2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_resp_rdata", resp_rdata, 32'd0);
    chk("midrst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h1, 1'b0, 0, "lw_0_after_rst");

    repeat (3) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Sequential responder for the processor's load/store port. It accepts one request at a time over a valid/ready handshake, waits a configurable number of cycles, and returns one response over a second valid/ready handshake. It commits stores and returns loads with RV32 byte, half and word semantics. It replaces the zero-latency data memory when the core is moved to a stalling memory interface.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit storage words; power of two, minimum 4.
- WAIT_CYCLES, 1: extra cycles between request acceptance and response; 0 to 15.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: reset, asynchronous assert, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request.
- req_we, input, 1: 1 = store, 0 = load.
- req_addr, input, 32: byte address.
- req_mode, input, 3: access mode, RV32 funct3 encoding.
- req_wdata, input, 32: store data; the low byte or half is used for narrow stores.
- resp_valid, output, 1: response present.
- resp_ready, input, 1: initiator accepts the response.
- resp_rdata, output, 32: load result after extension; 0 for stores and errors.
- resp_err, output, 1: misaligned access or illegal mode.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: latency counter running.
  - RESP: resp_valid=1.
- FSM transitions:
  - IDLE→WAIT on req_valid&req_ready when WAIT_CYCLES>0.
  - IDLE→RESP on the same condition when WAIT_CYCLES=0.
  - WAIT→RESP when the counter reaches WAIT_CYCLES-1.
  - RESP→IDLE on resp_ready.
- All req_* fields are registered at acceptance. Input changes after acceptance are ignored.
- Word index is req_addr[2+:log2(DEPTH_WORDS)]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS. Byte order is little-endian.
- Load modes:
  - 000 LB, 100 LBU: byte at addr[1:0], sign- or zero-extended.
  - 001 LH, 101 LHU: half at addr[1], sign- or zero-extended.
  - 010 LW: full word.
- Store modes: 000 SB, 001 SH, 010 SW, written with byte enables. Untouched bytes are preserved.
- Error conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load mode 011, 110 or 111.
  - Store mode other than 000, 001 or 010.
- Error response: resp_err=1, resp_rdata=0, no storage write.
- Storage is written on the clock edge that enters RESP. A load issued in the next transaction sees the new data.
- Storage contents are not reset.

## Timing
- Reset values:
  - State = IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Counter = 0.
- Response latency: resp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
- resp_rdata and resp_err are registered and stable while resp_valid=1. resp_valid holds until resp_ready is sampled high.
- req_ready=0 in WAIT and RESP. Throughput is at most one transaction per WAIT_CYCLES+2 cycles.
- A new request is never accepted on the same edge that completes a response. req_ready rises the cycle after the RESP→IDLE edge.
- resp_ready held high before resp_valid rises: the response completes after exactly one cycle of resp_valid.
- Reset mid-operation (WAIT or RESP):
  - The transaction is abandoned and outputs return to reset values.
  - A store is not written if reset asserts before the RESP-entry edge.

## Structure
- Package mem_pkg holds:
  - mem_mode_e: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - resp_state_e: IDLE, WAIT, RESP.
- Sub-module mem_align (combinational) holds:
  - Store path: byte-enable generation and write-data lane shifting.
  - Load path: lane extraction and sign/zero extension.
  - Misalignment and illegal-mode detection.
- Top level holds the FSM, the latency counter, the request registers and the storage array.

## Test plan
- WAIT_CYCLES=1: SW 0xDEADBEEF @0x10, then LW @0x10 → resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after each acceptance.
- After the above, SB 0x55 @0x11, then LW @0x10 → 0xDEAD55EF.
- LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x12 → 0x0000DEAD.
- LW @0x12, SH @0x11 and load mode 011 → resp_err=1, resp_rdata=0. A following LW @0x10 still returns 0xDEAD55EF.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid/resp_rdata stable and req_ready=0 throughout. req_ready=1 one cycle after resp_ready=1.
- Wrap and reset:
  - DEPTH_WORDS=1024: SW 0x1 @0x1000, then LW @0x0 → 0x1.
  - Assert rst during WAIT of SW 0x2 @0x0 → outputs at reset values; a subsequent LW @0x0 → 0x1.
